// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the gray_counter slice.
// Functions operate on MAX_WIDTH bits; callers zero-extend narrower values.
package gray_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction
endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder; mirror of the gray_to_binary stage.
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with coherent binary count, parallel load and wrap pulse.
// Optional step checker (single-bit-change) enabled by defining GRAY_CNT_CHECK_EN.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] B,
  output logic             wrap,
  output logic             err
);
  logic [WIDTH-1:0] b_step;
  logic [WIDTH-1:0] b_src;
  logic [WIDTH-1:0] g_src;
  logic             wrap_nxt;
  logic             step;

  always_comb begin
    b_step   = up_dn ? B + 1'b1 : B - 1'b1;
    wrap_nxt = up_dn ? (B == '1) : (B == '0);
    b_src    = load ? load_bin : b_step;
    step     = en && !load;
  end

  // Gray is always encoded from the value being registered, so G and B stay coherent
  bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
    .bin  (b_src),
    .gray (g_src)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      B    <= '0;
      G    <= '0;
      wrap <= 1'b0;
    end else begin
      if (load || en) begin
        B <= b_src;
        G <= g_src;
      end
      wrap <= step && wrap_nxt;
    end
  end

`ifdef GRAY_CNT_CHECK_EN
  logic [WIDTH-1:0] g_prev;
  logic             chk_vld;

  // Compare one cycle later against the G captured before the step
  always_ff @(posedge clk) begin
    if (rst) begin
      g_prev  <= '0;
      chk_vld <= 1'b0;
      err     <= 1'b0;
    end else begin
      chk_vld <= step;
      if (step) g_prev <= G;
      if (chk_vld && ($countones(G ^ g_prev) != 1)) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_counter.sv
// Directed + random bench for gray_counter with a queue-based scoreboard.
module tb_gray_counter;
  import gray_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] G;
  logic [W-1:0] B;
  logic         wrap;
  logic         err;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .G        (G),
    .B        (B),
    .wrap     (wrap),
    .err      (err)
  );

  typedef struct packed {
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         w;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] mb = '0;
  logic [W-1:0] gseq[17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                             4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                             4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic [W-1:0] lb, input string tag);
    exp_t                 x;
    logic                 mw;
    logic [MAX_WIDTH-1:0] t;
    @(negedge clk);
    rst = r; load = l; en = e; up_dn = u; load_bin = lb;
    mw = 1'b0;
    if (r) mb = '0;
    else if (l) mb = lb;
    else if (e) begin
      if (u) begin mw = (mb == 4'hF); mb = mb + 1'b1; end
      else begin mw = (mb == 4'h0); mb = mb - 1'b1; end
    end
    t = bin2gray({{(MAX_WIDTH-W){1'b0}}, mb});
    x.b = mb;
    x.g = t[W-1:0];
    x.w = mw;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, "_B"}, B, x.b);
    chk({tag, "_G"}, G, x.g);
    chk({tag, "_wrap"}, {3'b000, wrap}, {3'b000, x.w});
    chk({tag, "_err"}, {3'b000, err}, 4'b0000);
  endtask

  initial begin
    logic [MAX_WIDTH-1:0] cb;
    step(1, 0, 0, 1, 4'h0, "rst0");
    step(1, 0, 0, 1, 4'h0, "rst1");
    chk("reset_G", G, 4'b0000);
    for (int i = 0; i < 5; i++) step(0, 0, 0, i[0], 4'hA, "hold");

    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 1, 4'h0, "up");
      chk("up_seq", G, gseq[i+1]);
    end

    step(1, 0, 0, 1, 4'h0, "rst2");
    step(0, 0, 1, 0, 4'h0, "dn_wrap");
    chk("dn_wrap_B", B, 4'b1111);
    chk("dn_wrap_G", G, 4'b1000);
    chk("dn_wrap_w", {3'b000, wrap}, 4'b0001);
    step(0, 0, 1, 0, 4'h0, "dn_next");
    chk("dn_next_B", B, 4'b1110);
    chk("dn_next_G", G, 4'b1001);

    step(0, 1, 1, 1, 4'b1010, "load");
    chk("load_B", B, 4'b1010);
    chk("load_G", G, 4'b1111);
    step(0, 0, 1, 1, 4'h0, "load_up");
    chk("load_up_G", G, 4'b1110);
    step(1, 1, 1, 1, 4'b0101, "rst_ld");
    chk("rst_ld_B", B, 4'b0000);

    // reset while a wrap would otherwise be generated
    step(0, 1, 0, 0, 4'b1111, "ld_top");
    step(1, 0, 1, 1, 4'h0, "rst_wrap");
    chk("rst_wrap_w", {3'b000, wrap}, 4'b0000);

    step(0, 1, 0, 1, 4'b0110, "ld_0110");
    for (int i = 0; i < 40; i++) begin
      if (i == 20) step(0, 1, 1, 1, 4'b0110, "loop_ld");
      else step(0, 0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'h0, "loop");
      cb = gray2bin({{(MAX_WIDTH-W){1'b0}}, G});
      chk("loop_g2b", cb[W-1:0], B);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous up/down counter that produces a registered Gray-code sequence plus the matching binary count.
- Sits directly upstream of the gray_to_binary converter and is its stimulus and data source, e.g. FIFO pointers, encoder emulation and daily-practice benches.
- Guarantees exactly one output bit changes per count step, including at wrap-around.
- Supports parallel load, hold, direction control and a wrap flag.

Parameters:
- WIDTH, 4, counter and code width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; advance one step when high
- up_dn  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load strobe
- load_bin  input  WIDTH  binary value to load
- G  output  WIDTH  registered Gray-code count
- B  output  WIDTH  registered binary count, coherent with G
- wrap  output  1  one-cycle pulse on terminal-count rollover
- err  output  1  sticky step-check error (only with the optional feature; otherwise tied 0)

Behaviour:
- One clock, clk. Reset is synchronous and active-high: rst sampled high at a clk rising edge forces B=0, G=0, wrap=0, err=0. rst has priority over every other input.
- Priority: rst > load > en. If en=0 and load=0, all state holds and wrap=0.
- Load: at the edge where load=1, B<=load_bin and G<=load_bin^(load_bin>>1). wrap=0. Load is never counted as a step, even if en=1.
- Count: with en=1 and load=0:
  - up_dn=1: B<=B+1 mod 2^WIDTH.
  - up_dn=0: B<=B-1 mod 2^WIDTH.
  - G<=next_B^(next_B>>1), derived from the next binary value, never from the current one.
  - G and B therefore update on the same edge and are always consistent.
- Latency: one cycle from input sampling to output. No combinational path from inputs to outputs.
- Wrap:
  - wrap=1 for exactly the cycle after the edge on which B went from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down). Otherwise wrap=0.
  - wrap is registered.
- Direction change mid-sequence takes effect on the next enabled edge. No extra step or skipped code.
- Reset mid-count: the sequence restarts at 0 on the following cycle, wrap is cleared, and any pending wrap is suppressed.
- up_dn and load_bin are don't-care when not used.

Optional Feature:
- Macro: GRAY_CNT_CHECK_EN.
- When defined:
  - A registered checker compares the previous G with the new G after each count step.
  - If the Hamming distance is not exactly 1, err is set and stays set until rst.
  - Steps following load or rst are exempt.
- When undefined:
  - The checker logic is absent and err is driven constant 0.
  - Port list is unchanged.

Decomposition:
- Package gray_pkg:
  - function bin2gray(WIDTH);
  - function gray2bin(WIDTH);
  - localparam DEFAULT_WIDTH=4.
- One sub-module, bin_to_gray: combinational, parameter WIDTH, inputs binary and outputs Gray. It is the mirror of the gray_to_binary stage and is instantiated on the next-value path.
- Counter register, wrap detect and optional checker remain in gray_counter.

Test Plan:
- Reset/hold:
  - rst=1 for 2 cycles -> G=0000, B=0000, wrap=0, err=0.
  - en=0 for 5 cycles -> outputs unchanged.
- Full up cycle:
  - en=1, up_dn=1 from 0 for 16 edges -> G sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - wrap=1 only on the cycle showing 0000 after 1000 (B 15->0).
- Down wrap: from reset, en=1, up_dn=0, one edge -> B=1111, G=1000, wrap=1; next edge -> B=1110, G=1001, wrap=0.
- Load priority:
  - load=1, load_bin=1010, en=1 -> next cycle B=1010, G=1111, wrap=0.
  - Then count up -> B=1011, G=1110.
  - rst=1 asserted together with load -> B=0000.
- Closed loop: connect G to a gray_to_binary instance and run 40 random en/up_dn cycles -> converter output equals B every cycle.
  - With GRAY_CNT_CHECK_EN, err stays 0 throughout, including across a load of 0110.
